// File: rtl/tmon_cmd_master_pkg.sv
// Shared types for the temperature monitor command path: op codes, status
// codes, operand type, master state encoding and op classification.
package tmon_cmd_master_pkg;

   typedef logic       bool_t;
   typedef logic [7:0] DTYPE;

   typedef enum logic [3:0] {
      OP_RESET         = 4'h0,
      OP_SET_FRQ       = 4'h1,
      OP_SET_HIGH_TEMP = 4'h2,
      OP_SET_LOW_TEMP  = 4'h3,
      OP_OUT_MAX       = 4'h4,
      OP_OUT_MIN       = 4'h5,
      OP_OUT_ADDR      = 4'h6,
      OP_OUT_AVG       = 4'h7
   } TMOD_OP;

   // 2'b11 is reserved and treated as OK by the master
   typedef enum logic [1:0] {
      ST_OK   = 2'b00,
      ST_LOW  = 2'b01,
      ST_HIGH = 2'b10,
      ST_RSVD = 2'b11
   } TMOD_STATUS;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      ISSUE    = 2'd1,
      WAIT_RSP = 2'd2,
      DONE     = 2'd3
   } mstate_e;

   typedef enum logic [1:0] {
      OPC_WRITE = 2'd0,
      OPC_READ  = 2'd1,
      OPC_NOOP  = 2'd2
   } op_class_e;

   localparam int unsigned CNT_W = 16;

   // bit3 set: noop class; bit2 set: read ops; otherwise write ops
   function automatic op_class_e op_class(input logic [3:0] op);
      if (op[3])      return OPC_NOOP;
      else if (op[2]) return OPC_READ;
      else            return OPC_WRITE;
   endfunction

endpackage

// File: rtl/tmon_cmd_if.sv
// Command bus between the host-side master and the temperature monitor core.
interface tmon_cmd_if;
   import tmon_cmd_master_pkg::*;

   logic       cmd_valid;
   logic [3:0] cmd_op;
   DTYPE       cmd_data;
   logic       cmd_ack;
   logic       mon_rsp_valid;
   DTYPE       mon_rsp_data;
   logic [1:0] mon_rsp_status;

   modport master (
      output cmd_valid, cmd_op, cmd_data,
      input  cmd_ack, mon_rsp_valid, mon_rsp_data, mon_rsp_status
   );

   modport slave (
      input  cmd_valid, cmd_op, cmd_data,
      output cmd_ack, mon_rsp_valid, mon_rsp_data, mon_rsp_status
   );
endinterface

// File: rtl/tmon_cmd_master_timeout_ctr.sv
// Wait-cycle counter: cleared on entry to a waiting state, counts while
// enabled, flags expiry in the TIMEOUT_CYC-th enabled cycle.
module tmon_timeout_ctr
   import tmon_cmd_master_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYC = 255
) (
   input  logic clk,
   input  logic reset_n,
   input  logic clr,
   input  logic en,
   output logic expire
);

   localparam logic [CNT_W-1:0] TC = CNT_W'(TIMEOUT_CYC - 1);

   logic [CNT_W-1:0] cnt_q;

   // cycle count since entering the current waiting state
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)  cnt_q <= '0;
      else if (clr)  cnt_q <= '0;
      else if (en)   cnt_q <= cnt_q + CNT_W'(1);
   end

   // not gated by clr: clr is derived from the next state, which uses expire
   assign expire = en && (cnt_q == TC);

endmodule

// File: rtl/tmon_cmd_master.sv
// Host-side initiator: issues one op to the monitor, waits for ack/response,
// reports result, status, timeout and alarm flags.
//
//  state    | meaning
//  ---------+------------------------------------------------------------
//  IDLE     | req_ready high, waiting for a host request
//  ISSUE    | cmd_valid high (not for noop ops) until ack or timeout
//  WAIT_RSP | read op acked, waiting for mon_rsp_valid or timeout
//  DONE     | one-cycle done pulse, done_* valid
module tmon_cmd_master
   import tmon_cmd_master_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYC = 255,
   parameter bit          HOLD_STATUS = 1'b1
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       req_valid,
   output logic       req_ready,
   input  logic [3:0] req_op,
   input  DTYPE       req_data,
   tmon_cmd_if.master cmd,
   output logic       done,
   output DTYPE       done_data,
   output logic [1:0] done_status,
   output logic       done_timeout,
   output logic       alarm_high,
   output logic       alarm_low
);

   mstate_e    state_q, state_nxt;
   op_class_e  cls;
   logic [3:0] op_q;
   DTYPE       data_q;
   DTYPE       rdata_q;
   logic [1:0] status_q;
   logic       tmo_q;
   logic       alarm_high_q, alarm_low_q;
   logic       sample, tmo_set, rst_done, accept;
   logic       ctr_clr, ctr_en, expire;

   assign cls    = op_class(op_q);
   assign accept = (state_q == IDLE) && req_valid;

   // state register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_q <= IDLE;
      else          state_q <= state_nxt;
   end

   // next state; ack/response beats a same-cycle expiry
   always_comb begin
      state_nxt = state_q;
      sample    = 1'b0;
      tmo_set   = 1'b0;
      rst_done  = 1'b0;
      case (state_q)
         IDLE: begin
            if (req_valid) state_nxt = ISSUE;
         end
         ISSUE: begin
            if (cls == OPC_NOOP) begin
               state_nxt = DONE;
            end else if (cmd.cmd_ack) begin
               if (cls == OPC_WRITE) begin
                  state_nxt = DONE;
                  rst_done  = (op_q == OP_RESET);
               end else if (cmd.mon_rsp_valid) begin
                  state_nxt = DONE;
                  sample    = 1'b1;
               end else begin
                  state_nxt = WAIT_RSP;
               end
            end else if (expire) begin
               state_nxt = DONE;
               tmo_set   = 1'b1;
            end
         end
         WAIT_RSP: begin
            if (cmd.mon_rsp_valid) begin
               state_nxt = DONE;
               sample    = 1'b1;
            end else if (expire) begin
               state_nxt = DONE;
               tmo_set   = 1'b1;
            end
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   assign ctr_en  = (state_q == ISSUE) || (state_q == WAIT_RSP);
   assign ctr_clr = (state_nxt != state_q) &&
                    ((state_nxt == ISSUE) || (state_nxt == WAIT_RSP));

   tmon_timeout_ctr #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_tmo (
      .clk     (clk),
      .reset_n (reset_n),
      .clr     (ctr_clr),
      .en      (ctr_en),
      .expire  (expire)
   );

   // request capture and result latches
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         op_q     <= '0;
         data_q   <= '0;
         rdata_q  <= '0;
         status_q <= '0;
         tmo_q    <= 1'b0;
      end else begin
         if (accept) begin
            op_q    <= req_op;
            data_q  <= req_data;
            rdata_q <= '0;
            tmo_q   <= 1'b0;
         end
         if (sample) begin
            rdata_q  <= cmd.mon_rsp_data;
            status_q <= cmd.mon_rsp_status;
         end
         if (tmo_set) tmo_q <= 1'b1;
      end
   end

   // alarms: sticky until a completed RESET, or tracking the last status
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         alarm_high_q <= 1'b0;
         alarm_low_q  <= 1'b0;
      end else if (sample) begin
         if (HOLD_STATUS) begin
            alarm_high_q <= alarm_high_q | (cmd.mon_rsp_status == ST_HIGH);
            alarm_low_q  <= alarm_low_q  | (cmd.mon_rsp_status == ST_LOW);
         end else begin
            alarm_high_q <= (cmd.mon_rsp_status == ST_HIGH);
            alarm_low_q  <= (cmd.mon_rsp_status == ST_LOW);
         end
      end else if (HOLD_STATUS && rst_done) begin
         alarm_high_q <= 1'b0;
         alarm_low_q  <= 1'b0;
      end
   end

   assign req_ready     = (state_q == IDLE);
   assign done          = (state_q == DONE);
   assign cmd.cmd_valid = (state_q == ISSUE) && (cls != OPC_NOOP);
   assign cmd.cmd_op    = op_q;
   assign cmd.cmd_data  = data_q;
   assign done_data     = rdata_q;
   assign done_status   = status_q;
   assign done_timeout  = tmo_q;
   assign alarm_high    = alarm_high_q;
   assign alarm_low     = alarm_low_q;

endmodule

// File: tb/tb_tmon_cmd_master.sv
// Bench for tmon_cmd_master: directed scenarios plus random transactions,
// checked cycle by cycle against a timing/status model of the protocol.
module tb_tmon_cmd_master;

   localparam int T = 8;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       req_valid;
   logic       req_ready;
   logic [3:0] req_op;
   logic [7:0] req_data;
   logic       done;
   logic [7:0] done_data;
   logic [1:0] done_status;
   logic       done_timeout;
   logic       alarm_high;
   logic       alarm_low;

   int n_chk  = 0;
   int n_fail = 0;

   // reference model state: last accepted status and sticky alarms
   logic [1:0] m_status;
   bit         m_ah, m_al;

   tmon_cmd_if bus();

   tmon_cmd_master #(.TIMEOUT_CYC(T), .HOLD_STATUS(1'b1)) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_op       (req_op),
      .req_data     (req_data),
      .cmd          (bus),
      .done         (done),
      .done_data    (done_data),
      .done_status  (done_status),
      .done_timeout (done_timeout),
      .alarm_high   (alarm_high),
      .alarm_low    (alarm_low)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One host transaction. Cycle 0 is the accept cycle (req_valid high).
   // ack_j: ISSUE cycle index of the ack pulse (-1 = never).
   // rsp_k: cycles from ack to response (0 = same cycle as ack).
   // stray: for write ops, pulse mon_rsp_valid in the first ISSUE cycle.
   task automatic run_txn(input logic [3:0] op, input logic [7:0] d, input int ack_j,
                          input int rsp_k, input logic [7:0] rd, input logic [1:0] rs,
                          input bit stray);
      bit noop, rd_op, wr, acked, tmo, got_rsp, cv;
      int issue_last, done_c, ack_c, rsp_c, stray_c, last;
      logic [7:0] exp_data;
      noop    = op[3];
      rd_op   = !op[3] && op[2];
      wr      = !op[3] && !op[2];
      acked   = !noop && (ack_j >= 0) && (ack_j <= T - 1);
      tmo     = 1'b0;
      got_rsp = 1'b0;
      issue_last = 0;
      if (noop) begin
         done_c = 2;
      end else if (!acked) begin
         issue_last = T;
         done_c     = T + 1;
         tmo        = 1'b1;
      end else begin
         issue_last = 1 + ack_j;
         if (wr) begin
            done_c = 2 + ack_j;
         end else if (rsp_k <= T) begin
            done_c  = 2 + ack_j + rsp_k;
            got_rsp = 1'b1;
         end else begin
            done_c = 2 + ack_j + T;
            tmo    = 1'b1;
         end
      end
      ack_c   = (!noop && ack_j >= 0) ? 1 + ack_j : -1;
      rsp_c   = (rd_op && ack_j >= 0) ? 1 + ack_j + rsp_k : -1;
      stray_c = (stray && wr) ? 1 : -1;
      last = done_c + 1;
      if (ack_c > last) last = ack_c;
      if (rsp_c > last) last = rsp_c;

      if (got_rsp) begin
         m_status = rs;
         if (rs == 2'b01) m_al = 1'b1;
         if (rs == 2'b10) m_ah = 1'b1;
      end
      if (op == 4'h0 && !tmo) begin
         m_al = 1'b0;
         m_ah = 1'b0;
      end
      exp_data = got_rsp ? rd : 8'h00;

      for (int c = 0; c <= last; c++) begin
         cv = !noop && (c >= 1) && (c <= issue_last);
         chk($sformatf("req_ready op%0h c%0d", op, c), req_ready, (c == 0) || (c > done_c));
         chk($sformatf("done op%0h c%0d", op, c), done, c == done_c);
         chk($sformatf("cmd_valid op%0h c%0d", op, c), bus.cmd_valid, cv);
         if (cv) begin
            chk($sformatf("cmd_op op%0h c%0d", op, c), bus.cmd_op, op);
            if (wr && op != 4'h0)
               chk($sformatf("cmd_data op%0h c%0d", op, c), bus.cmd_data, d);
         end
         if (c == done_c) begin
            chk($sformatf("done_data op%0h", op), done_data, exp_data);
            chk($sformatf("done_timeout op%0h", op), done_timeout, tmo);
            chk($sformatf("done_status op%0h", op), done_status, m_status);
            chk($sformatf("alarm_high op%0h", op), alarm_high, m_ah);
            chk($sformatf("alarm_low op%0h", op), alarm_low, m_al);
         end
         req_valid          = (c == 0);
         req_op             = (c == 0) ? op : 4'($urandom);
         req_data           = (c == 0) ? d  : 8'($urandom);
         bus.cmd_ack        = (c == ack_c);
         bus.mon_rsp_valid  = (c == rsp_c) || (c == stray_c);
         bus.mon_rsp_data   = rd;
         bus.mon_rsp_status = rs;
         @(negedge clk);
      end
   endtask

   initial begin
      reset_n            = 1'b0;
      req_valid          = 1'b0;
      req_op             = 4'h0;
      req_data           = 8'h00;
      bus.cmd_ack        = 1'b0;
      bus.mon_rsp_valid  = 1'b0;
      bus.mon_rsp_data   = 8'h00;
      bus.mon_rsp_status = 2'b00;
      m_status = 2'b00;
      m_ah     = 1'b0;
      m_al     = 1'b0;

      repeat (2) @(negedge clk);
      chk("rst req_ready", req_ready, 1'b1);
      chk("rst done", done, 1'b0);
      chk("rst cmd_valid", bus.cmd_valid, 1'b0);
      chk("rst cmd_op", bus.cmd_op, 4'h0);
      chk("rst cmd_data", bus.cmd_data, 8'h00);
      chk("rst done_data", done_data, 8'h00);
      chk("rst done_status", done_status, 2'b00);
      chk("rst done_timeout", done_timeout, 1'b0);
      chk("rst alarm_high", alarm_high, 1'b0);
      chk("rst alarm_low", alarm_low, 1'b0);
      reset_n = 1'b1;
      @(negedge clk);

      // scenarios from the plan
      run_txn(4'h2, 8'h50, 3, 0, 8'h00, 2'b00, 1'b0);
      run_txn(4'h7, 8'h00, 1, 4, 8'h2A, 2'b10, 1'b0);
      chk("plan alarm_high", alarm_high, 1'b1);
      run_txn(4'hB, 8'h11, 0, 0, 8'h00, 2'b00, 1'b0);
      run_txn(4'h4, 8'h00, -1, 0, 8'h00, 2'b00, 1'b0);
      run_txn(4'h5, 8'h00, 0, 2, 8'h10, 2'b01, 1'b0);
      run_txn(4'h4, 8'h00, 0, 1, 8'h60, 2'b00, 1'b0);
      chk("sticky alarm_low", alarm_low, 1'b1);
      run_txn(4'h0, 8'h00, 0, 0, 8'h00, 2'b00, 1'b0);
      chk("reset op alarm_low", alarm_low, 1'b0);
      chk("reset op alarm_high", alarm_high, 1'b0);

      // expiry boundaries, same-cycle ack+response, stray inputs, code 2'b11
      run_txn(4'h1, 8'h33, T - 1, 0, 8'h00, 2'b00, 1'b0);
      run_txn(4'h6, 8'h00, 0, T, 8'h44, 2'b11, 1'b0);
      run_txn(4'h5, 8'h00, 1, T + 1, 8'h55, 2'b10, 1'b0);
      run_txn(4'h7, 8'h00, 2, 0, 8'h9C, 2'b01, 1'b0);
      run_txn(4'h3, 8'hC3, 2, 0, 8'hEE, 2'b10, 1'b1);
      run_txn(4'h1, 8'h01, T, 0, 8'h00, 2'b00, 1'b0);
      run_txn(4'h0, 8'h00, -1, 0, 8'h00, 2'b00, 1'b0);

      // reset while in ISSUE: cmd_valid drops without a clock edge
      req_valid = 1'b1; req_op = 4'h6; req_data = 8'h00;
      @(negedge clk);
      req_valid = 1'b0;
      chk("rst-issue cmd_valid before", bus.cmd_valid, 1'b1);
      #2 reset_n = 1'b0;
      #1;
      chk("rst-issue cmd_valid", bus.cmd_valid, 1'b0);
      chk("rst-issue req_ready", req_ready, 1'b1);
      chk("rst-issue done", done, 1'b0);
      @(negedge clk);
      reset_n = 1'b1;
      m_status = 2'b00; m_ah = 1'b0; m_al = 1'b0;
      @(negedge clk);

      // reset while in WAIT_RSP, then a late response in IDLE
      req_valid = 1'b1; req_op = 4'h5;
      @(negedge clk);
      req_valid = 1'b0; bus.cmd_ack = 1'b1;
      @(negedge clk);
      bus.cmd_ack = 1'b0;
      chk("rst-wait cmd_valid before", bus.cmd_valid, 1'b0);
      chk("rst-wait req_ready before", req_ready, 1'b0);
      #2 reset_n = 1'b0;
      #1;
      chk("rst-wait req_ready", req_ready, 1'b1);
      chk("rst-wait done", done, 1'b0);
      chk("rst-wait cmd_valid", bus.cmd_valid, 1'b0);
      @(negedge clk);
      reset_n = 1'b1;
      bus.mon_rsp_valid = 1'b1; bus.mon_rsp_data = 8'h77; bus.mon_rsp_status = 2'b01;
      @(negedge clk);
      bus.mon_rsp_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("late-rsp done %0d", i), done, 1'b0);
         chk($sformatf("late-rsp req_ready %0d", i), req_ready, 1'b1);
         chk($sformatf("late-rsp done_status %0d", i), done_status, m_status);
         chk($sformatf("late-rsp done_data %0d", i), done_data, 8'h00);
         chk($sformatf("late-rsp alarm_low %0d", i), alarm_low, m_al);
         chk($sformatf("late-rsp alarm_high %0d", i), alarm_high, m_ah);
         @(negedge clk);
      end

      // random transactions
      for (int n = 0; n < 40; n++) begin
         logic [3:0] r_op;
         int r_ack, r_rsp;
         r_op  = 4'($urandom);
         r_ack = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, T + 1));
         r_rsp = int'($urandom_range(0, T + 1));
         run_txn(r_op, 8'($urandom), r_ack, r_rsp, 8'($urandom), 2'($urandom),
                 1'($urandom));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/tmon_cmd_master.md
Name: tmon_cmd_master

Overview:
Host-side initiator for the temperature monitor command interface.
- Accepts one host request at a time: a TMOD_OP code plus an 8-bit DTYPE operand.
- Drives the request onto the monitor command bus and waits for the monitor's acknowledge or read response.
- Returns the result, the TMOD_STATUS and a timeout flag to the host.
- Sits between the system host/test controller and the monitor core. It is the issuing end of the protocol that the monitor decodes.

Parameters:
- TIMEOUT_CYC, 255: cycles to wait in ISSUE or WAIT_RSP before aborting; valid range 1..65535.
- HOLD_STATUS, 1: when 1, alarm_high/alarm_low stay set until a RESET op completes; when 0, they follow the last status received.

Ports:
- clk in 1: sole clock, rising edge.
- reset_n in 1: asynchronous active-low reset.
- req_valid in 1: host request valid.
- req_ready out 1: block can accept a request; high only in IDLE.
- req_op in 4: TMOD_OP code.
- req_data in 8: operand for SET_FRQ, SET_HIGH_TEMP and SET_LOW_TEMP; ignored for other ops.
- cmd_valid out 1: command valid to the monitor.
- cmd_op out 4: command code.
- cmd_data out 8: command operand.
- cmd_ack in 1: monitor accepted the command.
- mon_rsp_valid in 1: monitor read data valid, single-cycle pulse.
- mon_rsp_data in 8: read value.
- mon_rsp_status in 2: TMOD_STATUS.
- done out 1: single-cycle completion pulse.
- done_data out 8: read result; 0 for write ops.
- done_status out 2: last status sampled.
- done_timeout out 1: completion was an abort.
- alarm_high out 1: high-temperature alarm.
- alarm_low out 1: low-temperature alarm.

Behaviour:
Reset values (asynchronous, reset_n low):
- All outputs are 0, except req_ready = 1.
- State is IDLE.
- Timeout counter is 0.
- Latched op, data and status are 0; status 0 equals OK.

States:
- IDLE to ISSUE when req_valid is high.
  - On that edge, op and data are captured. req_ready drops the next cycle.
  - Any op code with bit3 = 1 is NOOP class: go directly to DONE with no bus activity, done_data 0, done_timeout 0.
- ISSUE:
  - cmd_valid = 1; cmd_op and cmd_data hold the captured values and stay stable until acknowledged.
  - On cmd_ack: write ops (RESET, SET_FRQ, SET_HIGH_TEMP, SET_LOW_TEMP) go to DONE; read ops (OUT_MAX, OUT_MIN, OUT_ADDR, OUT_AVG) go to WAIT_RSP.
  - cmd_valid deasserts the cycle after cmd_ack is sampled.
- WAIT_RSP:
  - cmd_valid = 0.
  - On mon_rsp_valid, capture mon_rsp_data and mon_rsp_status, then go to DONE.
  - mon_rsp_valid arriving in the same cycle as cmd_ack, while in ISSUE with a read op, is captured directly; go to DONE and skip WAIT_RSP.
- DONE:
  - Single cycle: done = 1, done_* valid.
  - Returns to IDLE; req_ready is high again the following cycle.

Latency:
- NOOP: done is asserted 2 cycles after the accept edge.
- Write op acked in the first ISSUE cycle: done 2 cycles after accept.
- Read op: done 1 cycle after mon_rsp_valid.

Timeout:
- A counter clears on entry to ISSUE and on entry to WAIT_RSP, and increments each cycle in those states.
- When it reaches TIMEOUT_CYC with no ack or response: go to DONE with done_timeout = 1 and done_data = 0; done_status keeps its previous value.
- If the terminating event arrives in the same cycle as expiry, the event wins and done_timeout = 0.

Stray inputs:
- cmd_ack or mon_rsp_valid arriving in IDLE or DONE is ignored.
- mon_rsp_valid during ISSUE for a write op is ignored.

Status and alarms:
- mon_rsp_status is sampled whenever mon_rsp_valid is high in an accepting state.
- Encoding: LOW sets alarm_low, HIGH sets alarm_high, code 2'b11 is treated as OK.
- HOLD_STATUS = 1: alarms are sticky; both clear when a RESET op completes without timeout.
- HOLD_STATUS = 0: alarms reflect the last sampled status only.

Reset mid-operation:
- reset_n low forces IDLE immediately; cmd_valid drops asynchronously.
- No done pulse is produced for the aborted request.

Decomposition:
- Shared package: TMOD_OP, TMOD_STATUS, DTYPE and bool_t stay where they are.
- Add to the package: a master-state enum (IDLE, ISSUE, WAIT_RSP, DONE) and a function that classifies an op as write, read or noop.
- Sub-module tmon_timeout_ctr: counter with clear, enable and expire outputs, parameterized by TIMEOUT_CYC.

Test Plan:
- SET_HIGH_TEMP with data 8'h50, monitor acks 3 cycles after cmd_valid -> cmd_op 4'b0010 and cmd_data 8'h50 stable until ack; done pulse with done_data 0 and done_timeout 0.
- OUT_AVG, ack after 1 cycle, mon_rsp_valid after 4 more cycles with data 8'h2A and status HIGH -> done_data 8'h2A, done_status 2'b10, alarm_high 1.
- NOOP op 4'b1011 -> no cmd_valid; done asserted 2 cycles after accept; req_ready high on the following cycle.
- OUT_MAX with TIMEOUT_CYC = 8 and no ack -> done_timeout 1 exactly 8 cycles into ISSUE; done_data 0.
- Sticky alarm: read returns LOW, then OK -> alarm_low stays 1; a RESET op acked -> alarm_low 0.
- reset_n pulsed low while in WAIT_RSP -> cmd_valid and done stay 0, req_ready 1; a late mon_rsp_valid is ignored.
